// File: rtl/i2cio.sv
// i2cio: CPU-bus I2C master peripheral. It generates START, 8-bit write/read with ACK
// and STOP on open-drain SCL/SDA enables, honours clock stretching and raises a level irq.
module i2cio #(
  parameter logic [15:0] PRESCALE_RESET = 16'd29
) (
  input  logic       clk,
  input  logic       rst,
  output logic       irq,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);
  typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  phase_reg, phase_next;
  logic [3:0]  bit_reg, bit_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        hold_reg, hold_next;
  logic        seq_done;

  logic [7:0]  data_reg, rx_reg;
  logic [6:0]  rx_sh_reg;
  logic [15:0] presc_reg;
  logic        ien_reg, if_reg, rxack_reg;
  logic        cmd_stop_reg, cmd_write_reg, cmd_read_reg, cmd_txnak_reg;

  logic bus_wr, bus_rd, busy, launch, stretch, tick, sample;

  assign bus_wr  = cs && !rw;
  assign bus_rd  = cs && rw;
  assign busy    = (state_reg != IDLE);
  assign launch  = bus_wr && (AD == 3'd1) && !busy && (DI[3:0] != 4'd0);
  // A released SCL that still reads low is a slave stretching the clock.
  assign stretch = busy && ((phase_reg == 2'd1) || (phase_reg == 2'd2)) && !scl_oe && !scl_in;
  assign tick    = busy && !stretch && (cnt_reg == 16'd0);
  assign sample  = tick && (state_reg == BIT) && (phase_reg == 2'd2);
  assign irq     = if_reg && ien_reg;

  // Pin drive is a pure function of the sequencer state, so reset releases both lines at once.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_reg)
      IDLE: scl_oe = hold_reg;
      START: begin
        scl_oe = (phase_reg == 2'd3);
        sda_oe = (phase_reg != 2'd0);
      end
      BIT: begin
        scl_oe = (phase_reg == 2'd0) || (phase_reg == 2'd3);
        if (bit_reg == 4'd8)
          sda_oe = cmd_read_reg && !cmd_txnak_reg;
        else
          sda_oe = cmd_write_reg && !data_reg[~bit_reg[2:0]];
      end
      STOP: begin
        scl_oe = (phase_reg == 2'd0);
        sda_oe = (phase_reg == 2'd0) || (phase_reg == 2'd1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    bit_next   = bit_reg;
    cnt_next   = cnt_reg;
    hold_next  = hold_reg;
    seq_done   = 1'b0;
    if (launch) begin
      phase_next = 2'd0;
      bit_next   = 4'd0;
      cnt_next   = presc_reg;
      if (DI[0])
        state_next = START;
      else if (DI[2] || DI[3])
        state_next = BIT;
      else
        state_next = STOP;
    end else if (busy) begin
      if (stretch || tick)
        cnt_next = presc_reg;
      else
        cnt_next = cnt_reg - 16'd1;
      if (tick) begin
        phase_next = phase_reg + 2'd1;
        if (phase_reg == 2'd3) begin
          case (state_reg)
            START: begin
              if (cmd_write_reg || cmd_read_reg) begin
                state_next = BIT;
                bit_next   = 4'd0;
              end else if (cmd_stop_reg) begin
                state_next = STOP;
              end else begin
                seq_done = 1'b1;
              end
            end
            BIT: begin
              if (bit_reg != 4'd8)
                bit_next = bit_reg + 4'd1;
              else if (cmd_stop_reg)
                state_next = STOP;
              else
                seq_done = 1'b1;
            end
            default: seq_done = 1'b1;
          endcase
          // Without a STOP the bus stays owned: SCL is parked low until the next command.
          if (seq_done) begin
            state_next = IDLE;
            hold_next  = (state_reg != STOP);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      phase_reg <= 2'd0;
      bit_reg   <= 4'd0;
      cnt_reg   <= 16'd0;
      hold_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      bit_reg   <= bit_next;
      cnt_reg   <= cnt_next;
      hold_reg  <= hold_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg      <= 8'h00;
      rx_reg        <= 8'h00;
      rx_sh_reg     <= 7'd0;
      presc_reg     <= PRESCALE_RESET;
      ien_reg       <= 1'b0;
      if_reg        <= 1'b0;
      rxack_reg     <= 1'b0;
      cmd_stop_reg  <= 1'b0;
      cmd_write_reg <= 1'b0;
      cmd_read_reg  <= 1'b0;
      cmd_txnak_reg <= 1'b0;
    end else begin
      if (bus_wr) begin
        case (AD)
          3'd0: data_reg <= DI;
          3'd1: ien_reg <= DI[7];
          3'd2: presc_reg[7:0] <= DI;
          3'd3: presc_reg[15:8] <= DI;
          default: ;
        endcase
      end
      if (launch) begin
        cmd_stop_reg  <= DI[1];
        cmd_write_reg <= DI[2];
        cmd_read_reg  <= DI[3] && !DI[2];
        cmd_txnak_reg <= DI[4];
      end
      if (seq_done)
        if_reg <= 1'b1;
      else if (launch || (bus_rd && (AD == 3'd0)))
        if_reg <= 1'b0;
      if (sample) begin
        if (bit_reg == 4'd8) begin
          if (cmd_write_reg)
            rxack_reg <= sda_in;
        end else if (cmd_read_reg) begin
          rx_sh_reg <= {rx_sh_reg[5:0], sda_in};
          if (bit_reg == 4'd7)
            rx_reg <= {rx_sh_reg, sda_in};
        end
      end
    end
  end

  always_comb begin
    case (AD)
      3'd0:    DO = rx_reg;
      3'd1:    DO = {ien_reg, if_reg, 4'b0000, rxack_reg, busy};
      3'd2:    DO = presc_reg[7:0];
      3'd3:    DO = presc_reg[15:8];
      default: DO = 8'hFF;
    endcase
  end
endmodule

// File: tb/tb_i2cio.sv
// Bench for i2cio: a bus monitor turns SCL/SDA activity into events (0/1 data bit,
// START, STOP) and pops them against a scoreboard queue filled when each command is issued.
module tb_i2cio;
  localparam int EV_START = 2;
  localparam int EV_STOP  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       irq;
  logic [2:0] AD = 3'd0;
  logic [7:0] DI = 8'h00;
  logic [7:0] DO;
  logic       rw = 1'b1;
  logic       cs = 1'b0;
  logic       scl_oe, sda_oe, scl_in, sda_in;
  logic       slave_scl_low = 1'b0;
  logic       slave_sda_low = 1'b0;
  logic [8:0] slave_pat = 9'h1FF;
  int         slot = 99;
  bit         mon_en = 1'b0;
  logic       scl_prev = 1'b1;
  logic       sda_prev = 1'b1;
  int         exp_q[$];
  int         checks = 0;
  int         errors = 0;

  // Open-drain bus with pull-ups.
  assign scl_in = !scl_oe && !slave_scl_low;
  assign sda_in = !sda_oe && !slave_sda_low;

  always #5 clk = ~clk;

  i2cio #(.PRESCALE_RESET(16'd29)) dut (
    .clk(clk), .rst(rst), .irq(irq), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in)
  );

  // Bus monitor and slave: slot counts SCL falling edges; slave_pat[8-slot] is the slave's SDA.
  initial begin : monitor
    int ev;
    int expv;
    logic [8:0] sh;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        ev = -1;
        if (!scl_prev && scl_in) ev = sda_in ? 1 : 0;
        else if (scl_prev && scl_in && sda_prev && !sda_in) ev = EV_START;
        else if (scl_prev && scl_in && !sda_prev && sda_in) ev = EV_STOP;
        if (ev >= 0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bus_event: got event %0d, required no event", ev);
          end else begin
            expv = exp_q.pop_front();
            if (ev != expv) begin
              errors++;
              $display("FAIL bus_event: got event %0d, required %0d", ev, expv);
            end else begin
              $display("bus event %0d ok", ev);
            end
          end
        end
        if (scl_prev && !scl_in && slot < 9) slot++;
      end
      if (mon_en && slot >= 0 && slot <= 8) begin
        sh = slave_pat << slot;
        slave_sda_low = !sh[8];
      end else begin
        slave_sda_low = 1'b0;
      end
      scl_prev = scl_in;
      sda_prev = !sda_oe && !slave_sda_low;
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    AD = a; DI = d; rw = 1'b0; cs = 1'b1;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
    $display("write reg %0d = %02h", a, d);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    AD = a; rw = 1'b1; cs = 1'b1;
    #1 d = DO;
    @(negedge clk);
    cs = 1'b0;
    $display("read reg %0d = %02h", a, d);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i] ? 1 : 0);
  endtask

  // Polls BUSY each cycle; counts SCL-pull edges to place a stretch or an abort point.
  task automatic run_seq(input int stretch_at, input int abort_at, output int cycles);
    int n;
    int hold_left;
    logic oe_prev;
    n = 0; hold_left = 0; cycles = 0;
    AD = 3'd1; rw = 1'b1; cs = 1'b1;
    #1;
    oe_prev = scl_oe;
    while (1) begin
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) slave_scl_low = 1'b0;
      end
      if (!oe_prev && scl_oe) begin
        n++;
        if (n == stretch_at) begin
          slave_scl_low = 1'b1;
          hold_left = 28;
        end
        if (n == abort_at) break;
      end
      oe_prev = scl_oe;
      if (!DO[0]) break;
      if (cycles >= 2000) begin
        checks++; errors++;
        $display("FAIL busy_timeout: BUSY still 1 after %0d cycles, required 0", cycles);
        break;
      end
      cycles++;
      @(negedge clk);
      #1;
    end
    cs = 1'b0;
  endtask

  task automatic test_reset;
    logic [2:0] addrs [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [7:0] exps  [5] = '{8'h00, 8'h1D, 8'h00, 8'hFF, 8'h00};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      AD = addrs[i];
      #1;
      checks++;
      if (DO !== exps[i]) begin
        errors++;
        $display("FAIL reset_reg%0d: DO=%02h, required %02h", addrs[i], DO, exps[i]);
      end
    end
    checks++;
    if ({scl_oe, sda_oe, irq} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pins: scl_oe/sda_oe/irq=%b, required 000", {scl_oe, sda_oe, irq});
    end
  endtask

  task automatic test_write_ack;
    int cycles;
    logic [7:0] d;
    mon_en = 1'b1;
    bus_write(3'd2, 8'h03);
    bus_write(3'd3, 8'h00);
    bus_write(3'd0, 8'hA0);
    bus_read(3'd2, d);
    checks++;
    if (d !== 8'h03) begin errors++; $display("FAIL presc_lo: got %02h, required 03", d); end
    slave_pat = 9'h1FE; slot = -1;
    exp_q.push_back(EV_START); push_byte(8'hA0); exp_q.push_back(0);
    bus_write(3'd1, 8'h85);
    run_seq(0, 0, cycles);
    checks++;
    if (cycles != 160) begin errors++; $display("FAIL write_ack_cycles: got %0d, required 160", cycles); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL write_ack_events: %0d left, required 0", exp_q.size()); end
    bus_read(3'd1, d);
    checks++;
    if (d !== 8'hC0) begin errors++; $display("FAIL write_ack_status: got %02h, required C0", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL write_ack_irq: got %b, required 1", irq); end
    bus_read(3'd0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL write_ack_rx: got %02h, required 00", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b, required 0", irq); end
  endtask

  task automatic test_write_nack;
    int cycles;
    logic [7:0] d;
    slave_pat = 9'h1FF; slot = -1;
    // From the parked bus, the repeated START first lets SCL rise with SDA high.
    exp_q.push_back(1); exp_q.push_back(EV_START); push_byte(8'hA0); exp_q.push_back(1);
    bus_write(3'd1, 8'h85);
    run_seq(0, 0, cycles);
    checks++;
    if (cycles != 160) begin errors++; $display("FAIL write_nack_cycles: got %0d, required 160", cycles); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL write_nack_events: %0d left, required 0", exp_q.size()); end
    bus_read(3'd1, d);
    checks++;
    if (d !== 8'hC2) begin errors++; $display("FAIL write_nack_status: got %02h, required C2", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL write_nack_irq: got %b, required 1", irq); end
  endtask

  task automatic test_read_stop;
    int cycles;
    logic [7:0] d;
    slave_pat = {8'h5C, 1'b1}; slot = 0;
    push_byte(8'h5C); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(EV_STOP);
    bus_write(3'd1, 8'h1A);
    run_seq(0, 0, cycles);
    checks++;
    if (cycles != 160) begin errors++; $display("FAIL read_cycles: got %0d, required 160", cycles); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL read_events: %0d left, required 0", exp_q.size()); end
    checks++;
    if ({scl_oe, sda_oe} !== 2'b00) begin errors++; $display("FAIL read_released: oe=%b, required 00", {scl_oe, sda_oe}); end
    bus_read(3'd1, d);
    checks++;
    if (d !== 8'h42) begin errors++; $display("FAIL read_status: got %02h, required 42", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL read_irq: got %b, required 0", irq); end
    bus_read(3'd0, d);
    checks++;
    if (d !== 8'h5C) begin errors++; $display("FAIL read_data: got %02h, required 5C", d); end
  endtask

  task automatic test_clock_stretch;
    int cycles;
    logic [7:0] d;
    bus_write(3'd0, 8'h3C);
    slave_pat = 9'h1FE; slot = -1;
    exp_q.push_back(EV_START); push_byte(8'h3C); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(EV_STOP);
    bus_write(3'd1, 8'h07);
    run_seq(4, 0, cycles);
    checks++;
    if (cycles != 196) begin errors++; $display("FAIL stretch_cycles: got %0d, required 196", cycles); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stretch_events: %0d left, required 0", exp_q.size()); end
    bus_read(3'd1, d);
    checks++;
    if (d !== 8'h40) begin errors++; $display("FAIL stretch_status: got %02h, required 40", d); end
  endtask

  task automatic test_busy_ignore;
    int cycles;
    logic [7:0] d;
    bus_write(3'd0, 8'h55);
    slave_pat = 9'h1FE; slot = -1;
    exp_q.push_back(EV_START); push_byte(8'h55); exp_q.push_back(0);
    bus_write(3'd1, 8'h05);
    bus_write(3'd1, 8'h04);
    run_seq(0, 0, cycles);
    checks++;
    if (cycles != 158) begin errors++; $display("FAIL busy_ignore_cycles: got %0d, required 158", cycles); end
    repeat (200) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL busy_ignore_events: %0d left, required 0", exp_q.size()); end
    bus_read(3'd1, d);
    checks++;
    if (d !== 8'h40) begin errors++; $display("FAIL busy_ignore_status: got %02h, required 40", d); end
  endtask

  task automatic test_reset_mid_transfer;
    int cycles;
    mon_en = 1'b0;
    exp_q.delete();
    bus_write(3'd1, 8'h07);
    run_seq(0, 2, cycles);
    checks++;
    if ({scl_oe, sda_oe} !== 2'b11) begin errors++; $display("FAIL mid_pre: oe=%b, required 11", {scl_oe, sda_oe}); end
    #2 rst = 1'b1;
    AD = 3'd1;
    #1;
    checks++;
    if ({scl_oe, sda_oe, irq} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_pins: scl_oe/sda_oe/irq=%b, required 000", {scl_oe, sda_oe, irq});
    end
    checks++;
    if (DO !== 8'h00) begin errors++; $display("FAIL mid_reset_status: got %02h, required 00", DO); end
    AD = 3'd2;
    #1;
    checks++;
    if (DO !== 8'h1D) begin errors++; $display("FAIL mid_reset_presc: got %02h, required 1D", DO); end
    AD = 3'd0;
    #1;
    checks++;
    if (DO !== 8'h00) begin errors++; $display("FAIL mid_reset_rx: got %02h, required 00", DO); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    AD = 3'd1;
    #1;
    checks++;
    if ({DO, scl_oe, sda_oe} !== 10'h000) begin
      errors++;
      $display("FAIL post_reset_idle: status=%02h oe=%b, required 00/00", DO, {scl_oe, sda_oe});
    end
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_write_nack();
    test_read_stop();
    test_clock_stretch();
    test_busy_ignore();
    test_reset_mid_transfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
